// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchroniser, clock filter, frame FSM, E0/F0 decoder, event FIFO.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make events of the held key.
module ps2_key_event_rx #(
  parameter int SYNC_STAGES = 3,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2k_clk,
  input  logic               ps2k_data,
  input  logic               ev_rd,
  output logic               ev_valid,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_brk,
  output logic [FIFO_AW:0]   ev_count,
  output logic               key_held,
  output logic               err_parity,
  output logic               err_frame,
  output logic               ovf,
  input  logic               err_clr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] csync;
  logic [SYNC_STAGES-1:0] dsync;
  logic                   sclk;
  logic                   sdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      csync <= '1;
      dsync <= '1;
    end else begin
      csync <= {csync[SYNC_STAGES-2:0], ps2k_clk};
      dsync <= {dsync[SYNC_STAGES-2:0], ps2k_data};
    end
  end

  assign sclk  = csync[SYNC_STAGES-1];
  assign sdata = dsync[SYNC_STAGES-1];

  logic [FW-1:0] fcnt;
  logic          filt;
  logic          change;
  logic          fall;

  // The filtered level flips on the FILT_LEN-th consecutive differing sample.
  assign change = (sclk != filt) && (fcnt == FW'(FILT_LEN - 1));
  assign fall   = change && filt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (sclk == filt) begin
      fcnt <= '0;
    end else if (change) begin
      filt <= sclk;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  logic [1:0]    state;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          par;
  logic          byte_valid;
  logic [TW-1:0] tcnt;
  logic          tmo;

  // Registered err_frame then lands exactly TIMEOUT_CYC cycles after the edge.
  assign tmo = (state != S_IDLE) && !fall &&
               (tcnt == TW'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk) begin
    if (!rst || fall || state == S_IDLE) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      sh         <= '0;
      par        <= 1'b0;
      byte_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (tmo) begin
        state     <= S_IDLE;
        err_frame <= 1'b1;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!sdata) begin
              state <= S_DATA;
              bcnt  <= '0;
            end
          end
          S_DATA: begin
            sh   <= {sdata, sh[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= sdata;
            state <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (!sdata)             err_frame  <= 1'b1;
            else if (!(^{sh, par})) err_parity <= 1'b1;
            else                    byte_valid <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic       ext;
  logic       brk;
  logic [8:0] rec;
  logic       is_pfx;
  logic       evt;
  logic       rep;
  logic       push;

  assign is_pfx = (sh == 8'hE0) || (sh == 8'hF0);
  assign evt    = byte_valid && !is_pfx;
  assign rep    = !brk && key_held && ({ext, sh} == rec);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign push = evt && !rep;
`else
  assign push = evt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (err_parity || err_frame) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      if (sh == 8'hE0) begin
        ext <= 1'b1;
      end else if (sh == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_held <= 1'b0;
      rec      <= '0;
    end else if (push) begin
      if (!brk) begin
        key_held <= 1'b1;
        rec      <= {ext, sh};
      end else if ({ext, sh} == rec) begin
        key_held <= 1'b0;
      end
    end
  end

  logic [9:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wp;
  logic [FIFO_AW-1:0] rp;
  logic [FIFO_AW:0]   cnt;
  logic               full;
  logic               pop;
  logic               wr;
  logic               drop;
  logic [9:0]         head;

  assign full = (cnt == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop  = ev_rd && (cnt != '0);
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {ext, brk, sh};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A new drop outranks a simultaneous clear.
      if (drop)         ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
    end
  end

  assign head     = mem[rp];
  assign ev_valid = (cnt != '0);
  assign ev_count = cnt;
  assign ev_code  = ev_valid ? head[7:0] : 8'h00;
  assign ev_brk   = ev_valid && head[8];
  assign ev_ext   = ev_valid && head[9];

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: frame table plus latency, timeout,
// reset, FIFO overflow and typematic sequences.
module tb_ps2_key_event_rx;

  localparam int TO = 300;
  localparam int H  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic       ev_rd = 1'b0;
  logic       err_clr = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic [3:0] ev_count;
  logic       key_held;
  logic       err_parity;
  logic       err_frame;
  logic       ovf;

  int napplied = 0;
  int nfail = 0;
  int npar = 0;
  int nfrm = 0;

  ps2_key_event_rx #(
    .SYNC_STAGES(3), .FILT_LEN(4), .TIMEOUT_CYC(TO),
    .FIFO_DEPTH(8), .FIFO_AW(3)
  ) dut (
    .clk(clk), .rst(rst), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
    .ev_rd(ev_rd), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_count(ev_count),
    .key_held(key_held), .err_parity(err_parity),
    .err_frame(err_frame), .ovf(ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_parity) npar++;
    if (err_frame) nfrm++;
  end

  typedef struct {
    logic [7:0] code;
    bit         flip;
    bit         stopb;
    int         cnt;
    logic [7:0] ecode;
    bit         eext;
    bit         ebrk;
    int         dpar;
    int         dfrm;
    bit         held;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int act, input int exp);
    napplied++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk) ps2k_data = b;
    repeat (H) @(negedge clk);
    ps2k_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2k_clk = 1'b1;
  endtask

  // mode: 0 plain, 1 latency check, 2 ev_rd on push cycle, 3 err_clr on push cycle
  task automatic send_frame(input logic [7:0] code, input bit flip,
                            input bit stopb, input int mode);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ flip);
    @(negedge clk) ps2k_data = stopb;
    repeat (H) @(negedge clk);
    ps2k_clk = 1'b0;
    for (int k = 0; k < 2 * H; k++) begin
      @(posedge clk);
      #1;
      if (mode == 1 && k == 6) chk("lat_pre", int'(ev_valid), 0);
      if (mode == 1 && k == 7) chk("lat_at", int'(ev_valid), 1);
      if (mode == 2 && k == 6) ev_rd = 1'b1;
      if (mode == 3 && k == 6) err_clr = 1'b1;
      if (k == 7) begin
        ev_rd = 1'b0;
        err_clr = 1'b0;
      end
      if (k == H) ps2k_clk = 1'b1;
    end
    ps2k_data = 1'b1;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] c,
                         input bit e, input bit b);
    @(negedge clk);
    chk({name, "_valid"}, int'(ev_valid), 1);
    chk({name, "_code"}, int'(ev_code), int'(c));
    chk({name, "_ext"}, int'(ev_ext), int'(e));
    chk({name, "_brk"}, int'(ev_brk), int'(b));
    ev_rd = 1'b1;
    @(negedge clk) ev_rd = 1'b0;
  endtask

  initial begin
    int p0, f0, exp_n;
    logic [7:0] exp_codes [8];

    tbl[0]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[1]  = '{8'h75, 0, 1, 1, 8'h75, 1, 0, 0, 0, 1};
    tbl[2]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[3]  = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[4]  = '{8'h75, 0, 1, 1, 8'h75, 1, 1, 0, 0, 0};
    tbl[5]  = '{8'h1C, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0};
    tbl[6]  = '{8'h1D, 0, 1, 1, 8'h1D, 0, 0, 0, 0, 1};
    tbl[7]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1};
    tbl[8]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[9]  = '{8'h1C, 1, 1, 0, 8'h00, 0, 0, 1, 0, 1};
    tbl[10] = '{8'h5A, 0, 1, 1, 8'h5A, 0, 0, 0, 0, 1};
    tbl[11] = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[12] = '{8'h1C, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1};
    tbl[13] = '{8'h29, 0, 1, 1, 8'h29, 0, 0, 0, 0, 1};
    tbl[14] = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[15] = '{8'h1C, 0, 1, 1, 8'h1C, 0, 1, 0, 0, 1};
    tbl[16] = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[17] = '{8'h29, 0, 1, 1, 8'h29, 0, 1, 0, 0, 0};

    repeat (4) @(negedge clk);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_count", int'(ev_count), 0);
    chk("rst_code", int'(ev_code), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_errs", int'({err_parity, err_frame}), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h1C, 0, 1, 1);
    chk("lat_held", int'(key_held), 1);
    pop_chk("lat_ev", 8'h1C, 0, 0);

    foreach (tbl[i]) begin
      p0 = npar;
      f0 = nfrm;
      send_frame(tbl[i].code, tbl[i].flip, tbl[i].stopb, 0);
      repeat (4) @(negedge clk);
      chk($sformatf("row%0d_count", i), int'(ev_count), tbl[i].cnt);
      chk($sformatf("row%0d_par", i), npar - p0, tbl[i].dpar);
      chk($sformatf("row%0d_frm", i), nfrm - f0, tbl[i].dfrm);
      chk($sformatf("row%0d_held", i), int'(key_held), int'(tbl[i].held));
      if (tbl[i].cnt == 1)
        pop_chk($sformatf("row%0d", i), tbl[i].ecode, tbl[i].eext, tbl[i].ebrk);
    end

    // Partial frame: start + 4 data bits, then silence until timeout.
    f0 = nfrm;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk) ps2k_data = 1'b0;
    repeat (H) @(negedge clk);
    ps2k_clk = 1'b0;
    for (int k = 0; k <= 5 + TO; k++) begin
      @(posedge clk);
      #1;
      if (k == H) ps2k_clk = 1'b1;
      if (k == 4 + TO) chk("tmo_pre", int'(err_frame), 0);
      if (k == 5 + TO) chk("tmo_at", int'(err_frame), 1);
    end
    ps2k_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("tmo_pulses", nfrm - f0, 1);
    chk("tmo_count", int'(ev_count), 0);
    send_frame(8'h33, 0, 1, 0);
    repeat (4) @(negedge clk);
    pop_chk("tmo_next", 8'h33, 0, 0);

    // Reset in the middle of a frame.
    p0 = npar;
    f0 = nfrm;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (TO + 20) @(negedge clk);
    chk("mrst_errs", (npar - p0) + (nfrm - f0), 0);
    chk("mrst_valid", int'(ev_valid), 0);
    send_frame(8'h44, 0, 1, 0);
    repeat (4) @(negedge clk);
    pop_chk("mrst_next", 8'h44, 0, 0);

    // Overflow: nine events into eight slots.
    for (int i = 0; i < 9; i++) send_frame(8'h15 + 8'(i), 0, 1, 0);
    repeat (4) @(negedge clk);
    chk("ovf_count", int'(ev_count), 8);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_head", int'(ev_code), 8'h15);
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);
    send_frame(8'h40, 0, 1, 3);
    repeat (2) @(negedge clk);
    chk("ovf_setwins", int'(ovf), 1);
    chk("ovf_count2", int'(ev_count), 8);
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("ovf_clr2", int'(ovf), 0);
    send_frame(8'h41, 0, 1, 2);
    repeat (2) @(negedge clk);
    chk("pp_count", int'(ev_count), 8);
    chk("pp_ovf", int'(ovf), 0);
    for (int i = 0; i < 7; i++) exp_codes[i] = 8'h16 + 8'(i);
    exp_codes[7] = 8'h41;
    for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i), exp_codes[i], 0, 0);
    chk("drain_count", int'(ev_count), 0);
    @(negedge clk) ev_rd = 1'b1;
    @(negedge clk) ev_rd = 1'b0;
    chk("empty_rd", int'(ev_count), 0);

    // Typematic repeats followed by the release.
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    repeat (4) @(negedge clk);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    chk("typ_count", int'(ev_count), exp_n);
    chk("typ_held", int'(key_held), 0);
    for (int i = 0; i < exp_n - 1; i++) pop_chk($sformatf("typ_mk%0d", i), 8'h1C, 0, 0);
    pop_chk("typ_brk", 8'h1C, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
    $finish;
  end

endmodule
